cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of result producers sharing the CDB (0 add RS, 1 mul RS, 2 load buffer, 3 branch unit).
REQ-002 Parameter DEPTH, default 2: entries in each per-requester holding FIFO.
REQ-003 Parameter ROB_W, default 6: ROB tag width.
REQ-004 Parameter DATA_W, default 32: result data width.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 flush  input  1  synchronous mispredict flush; discards all pending results.
REQ-008 req_valid  input  NUM_REQ  per-requester result-valid strobe.
REQ-009 req_rob  input  NUM_REQ*ROB_W  per-requester destination ROB tag; requester i at bits [i*ROB_W +: ROB_W].
REQ-010 req_data  input  NUM_REQ*DATA_W  per-requester result value; requester i at bits [i*DATA_W +: DATA_W].
REQ-011 req_ready  output  NUM_REQ  per-requester "FIFO can accept".
REQ-012 cdb_valid  output  1  registered CDB broadcast strobe.
REQ-013 cdb_rob  output  ROB_W  registered broadcast ROB tag.
REQ-014 cdb_data  output  DATA_W  registered broadcast value.

Function
REQ-015 req_ready[i] SHALL equal (count[i] != DEPTH), from registered count only; never combinationally dependent on the same-cycle pop.
REQ-016 On each edge with req_valid[i] && req_ready[i], {req_rob[i], req_data[i]} SHALL be pushed into FIFO i.
REQ-017 req_valid[i] while req_ready[i]=0 SHALL be ignored; the requester holds its result and retries.
REQ-018 Each edge, arbiter SHALL pop at most one entry total: the head of the first non-empty FIFO scanning round-robin from (last_grant+1) mod NUM_REQ.
REQ-019 Popped entry SHALL drive cdb_valid=1, cdb_rob and cdb_data on that same edge; cdb_valid=0 when all FIFOs are empty.
REQ-020 last_grant SHALL update only on a pop; it is unchanged on idle cycles.
REQ-021 Latency: a result pushed at edge t SHALL appear on the CDB no earlier than edge t+1; no push-to-CDB bypass.
REQ-022 Same-edge push and pop on one FIFO SHALL both take effect; count unchanged; order preserved.
REQ-023 Each FIFO SHALL be strict FIFO with wrap-around read/write pointers modulo DEPTH.
REQ-024 cdb_rob and cdb_data SHALL hold their last values while cdb_valid=0.
REQ-025 flush=1 at an edge SHALL empty all FIFOs, drop same-edge pushes, force cdb_valid=0, and retain last_grant.
REQ-026 Bounded wait: with all FIFOs continuously non-empty, each requester SHALL be granted once every NUM_REQ cycles.

Reset
REQ-027 Reset assertion SHALL immediately clear all FIFO counts and pointers, and set cdb_valid=0, cdb_rob=6'b010000 (invalid tag), cdb_data=0, and last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-028 After reset release, req_ready SHALL read all ones; reset asserted mid-traffic SHALL lose all pending entries without any broadcast.

Structure
REQ-029 A shared package SHALL hold ROB_W, DATA_W, the invalid tag 6'b010000, and the requester index constants.
REQ-030 The per-requester holding queue SHALL be one sub-module, cdb_fifo (DEPTH x (ROB_W+DATA_W), push/pop/count, synchronous flush), instantiated NUM_REQ times; round-robin select SHALL stay in cdb_arbiter.

Verification
REQ-031 After reset, push req0 {rob=5, data=0x0000_0011} at edge 1 -> cdb_valid=1, rob=5, data=0x11 after edge 2; cdb_valid=0 after edge 3.
REQ-032 Push req0..3 simultaneously, rob=1..4 -> broadcasts after edges 2,3,4,5 carry rob 1,2,3,4; last_grant=3.
REQ-033 Hold req2 valid for 4 cycles, rob=8..11, no other traffic -> ready[2] stays 1 (push+pop balance), CDB carries 8,9,10,11 in order.
REQ-034 Fill FIFO1 to 2 entries, then assert req1 while FIFOs 0 and 2 are also full -> ready[1]=0, offered entry not captured; captured entries broadcast exactly once.
REQ-035 With 3 entries pending, assert flush -> cdb_valid=0 next cycle, all ready=1, no further broadcast of those tags.
REQ-036 Assert reset asynchronously mid-burst between edges -> cdb_valid falls immediately, cdb_rob=0x10, and the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared constants for the common-data-bus arbiter
package cdb_arbiter_pkg;

  localparam int ROB_W  = 6;
  localparam int DATA_W = 32;

  localparam logic [5:0] INVALID_TAG = 6'b010000;

  // Result producers, in their fixed CDB port order.
  localparam int REQ_ADD    = 0;
  localparam int REQ_MUL    = 1;
  localparam int REQ_LOAD   = 2;
  localparam int REQ_BRANCH = 3;

  localparam int NUM_REQ_DEF = REQ_BRANCH + 1;

  // k-th candidate after the last winner in round-robin order.
  function automatic int rr_next(input int last, input int k, input int n);
    return (last + k) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - producer-side result ports and CDB broadcast bundle
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ROB_W   = cdb_arbiter_pkg::ROB_W,
  parameter int DATA_W  = cdb_arbiter_pkg::DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ROB_W-1:0]  req_rob;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cdb_valid;
  logic [ROB_W-1:0]          cdb_rob;
  logic [DATA_W-1:0]         cdb_data;

  modport master (
    output req_valid, req_rob, req_data,
    input  req_ready, cdb_valid, cdb_rob, cdb_data
  );

  modport slave (
    input  req_valid, req_rob, req_data,
    output req_ready, cdb_valid, cdb_rob, cdb_data
  );

endinterface

// File: rtl/cdb_fifo.sv
// rtl/cdb_fifo.sv - per-producer holding queue with wrap-around pointers and synchronous flush
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 38
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common-data-bus arbiter over per-producer holding FIFOs
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DEPTH   = 2,
  parameter int ROB_W   = cdb_arbiter_pkg::ROB_W,
  parameter int DATA_W  = cdb_arbiter_pkg::DATA_W
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  cdb_arbiter_if.slave    bus
);

  localparam int ENTRY_W = ROB_W + DATA_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int GNT_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [CNT_W-1:0]   count [NUM_REQ];
  logic [ENTRY_W-1:0] head  [NUM_REQ];
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] nonempty;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;

  logic [GNT_W-1:0]   last_grant;
  logic [GNT_W-1:0]   grant;
  logic [GNT_W-1:0]   cand;
  logic               found;

  logic               cdb_valid_q;
  logic [ROB_W-1:0]   cdb_rob_q;
  logic [DATA_W-1:0]  cdb_data_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    // Ready comes only from the registered count, so a full FIFO refuses even on a popping edge.
    assign ready[i]    = (count[i] != CNT_W'(DEPTH));
    assign nonempty[i] = (count[i] != '0);
    assign push[i]     = bus.req_valid[i] && ready[i] && !flush;
    assign pop[i]      = found && !flush && (grant == GNT_W'(i));

    cdb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .push      (push[i]),
      .push_data ({bus.req_rob[i*ROB_W +: ROB_W], bus.req_data[i*DATA_W +: DATA_W]}),
      .pop       (pop[i]),
      .head      (head[i]),
      .count     (count[i])
    );
  end

  // Scan from the requester after the last winner; only already-queued entries compete.
  always_comb begin
    grant = last_grant;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GNT_W'(rr_next(int'(last_grant), k, NUM_REQ));
      if (!found && nonempty[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_valid_q <= 1'b0;
      cdb_rob_q   <= ROB_W'(INVALID_TAG);
      cdb_data_q  <= '0;
      last_grant  <= GNT_W'(NUM_REQ - 1);
    end else if (flush) begin
      cdb_valid_q <= 1'b0;
    end else if (found) begin
      cdb_valid_q               <= 1'b1;
      {cdb_rob_q, cdb_data_q}   <= head[grant];
      last_grant                <= grant;
    end else begin
      cdb_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = ready;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_rob   = cdb_rob_q;
  assign bus.cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized and directed bench for cdb_arbiter against a queue model
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int D  = 2;
  localparam int RW = 6;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset;
  logic flush;

  always #5 clock = ~clock;

  cdb_arbiter_if #(.NUM_REQ(N), .ROB_W(RW), .DATA_W(DW)) bus();

  cdb_arbiter #(.NUM_REQ(N), .DEPTH(D), .ROB_W(RW), .DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  int n_pass   = 0;
  int n_checks = 0;

  // Reference model: one queue per producer, plus the broadcast the bus should show.
  logic [RW+DW-1:0] mq [N][$];
  int               m_last;
  logic             m_valid;
  logic [RW-1:0]    m_rob;
  logic [DW-1:0]    m_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_last  = N - 1;
    m_valid = 1'b0;
    m_rob   = 6'h10;
    m_data  = '0;
  endtask

  task automatic model_edge();
    int pick;
    logic [N-1:0] rdy;
    pick = -1;
    for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < D);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (pick < 0 && mq[c].size() > 0) pick = c;
    end
    if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_valid = 1'b0;
    end else begin
      if (pick >= 0) begin
        {m_rob, m_data} = mq[pick].pop_front();
        m_valid = 1'b1;
        m_last  = pick;
      end else begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < N; i++)
        if (bus.req_valid[i] && rdy[i])
          mq[i].push_back({bus.req_rob[i*RW +: RW], bus.req_data[i*DW +: DW]});
    end
  endtask

  // Inputs are already settled; check ready, advance one edge, then check the broadcast.
  task automatic tick();
    for (int i = 0; i < N; i++)
      check($sformatf("ready%0d", i), 64'(bus.req_ready[i]), 64'(mq[i].size() < D));
    @(posedge clock);
    model_edge();
    #1;
    check("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
    check("cdb_rob",   64'(bus.cdb_rob),   64'(m_rob));
    check("cdb_data",  64'(bus.cdb_data),  64'(m_data));
  endtask

  task automatic drive(input int i, input logic v, input logic [RW-1:0] rob, input logic [DW-1:0] data);
    bus.req_valid[i]         = v;
    bus.req_rob[i*RW +: RW]  = rob;
    bus.req_data[i*DW +: DW] = data;
  endtask

  task automatic clear_req();
    bus.req_valid = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_req();
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic async_reset_mid();
    #3;
    reset = 1'b1;
    #1;
    check("arst_valid", 64'(bus.cdb_valid), 64'(0));
    check("arst_rob",   64'(bus.cdb_rob),   64'(6'h10));
    check("arst_data",  64'(bus.cdb_data),  64'(0));
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tag [N];
    reset         = 1'b1;
    flush         = 1'b0;
    bus.req_valid = '0;
    bus.req_rob   = '0;
    bus.req_data  = '0;
    model_reset();
    #1;
    check("rst_valid", 64'(bus.cdb_valid), 64'(0));
    check("rst_rob",   64'(bus.cdb_rob),   64'(6'h10));
    check("rst_data",  64'(bus.cdb_data),  64'(0));
    check("rst_ready", 64'(bus.req_ready), 64'(4'hf));
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Single result: visible one edge after capture, then the bus idles.
    drive(0, 1'b1, 6'd5, 32'h11);
    tick();
    clear_req();
    tick();
    check("one_valid", 64'(bus.cdb_valid), 64'(1));
    check("one_rob",   64'(bus.cdb_rob),   64'(5));
    check("one_data",  64'(bus.cdb_data),  64'(32'h11));
    tick();
    check("one_idle",  64'(bus.cdb_valid), 64'(0));
    check("one_hold",  64'(bus.cdb_rob),   64'(5));

    // All four at once: broadcast in requester order 0..3.
    do_reset();
    for (int i = 0; i < N; i++) drive(i, 1'b1, RW'(i + 1), DW'(32'h100 + i));
    tick();
    clear_req();
    for (int k = 0; k < N; k++) begin
      tick();
      check($sformatf("rr_order%0d", k), 64'(bus.cdb_rob), 64'(k + 1));
    end

    // Streaming one requester: push and pop balance, order preserved.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(2, 1'b1, RW'(8 + k), DW'(k));
      tick();
      if (k > 0) check($sformatf("stream%0d", k), 64'(bus.cdb_rob), 64'(7 + k));
    end
    clear_req();
    tick();
    check("stream_last", 64'(bus.cdb_rob), 64'(11));

    // Back-pressure: requesters 0..2 hold each result until it is accepted.
    do_reset();
    for (int i = 0; i < N; i++) tag[i] = 16 + 8 * i;
    for (int c = 0; c < 8; c++) begin
      logic [N-1:0] acc;
      for (int i = 0; i < 3; i++) begin
        drive(i, 1'b1, RW'(tag[i]), DW'(tag[i] * 3));
        acc[i] = (mq[i].size() < D);
      end
      tick();
      for (int i = 0; i < 3; i++) if (acc[i]) tag[i]++;
    end
    clear_req();
    for (int c = 0; c < 8; c++) tick();
    check("bp_drained", 64'(bus.cdb_valid), 64'(0));

    // Flush with three pending entries.
    do_reset();
    for (int i = 0; i < 3; i++) drive(i, 1'b1, RW'(40 + i), DW'(i));
    tick();
    clear_req();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", 64'(bus.cdb_valid), 64'(0));
    tick();
    check("flush_ready", 64'(bus.req_ready), 64'(4'hf));
    tick();
    check("flush_quiet", 64'(bus.cdb_valid), 64'(0));

    // Asynchronous reset mid-burst; requester 0 wins first afterwards.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) drive(i, 1'b1, RW'(c * 4 + i), DW'($urandom));
      tick();
    end
    async_reset_mid();
    for (int i = 0; i < N; i++) drive(i, 1'b1, RW'(20 + i), DW'(i));
    tick();
    clear_req();
    tick();
    check("post_rst_first", 64'(bus.cdb_rob), 64'(20));
    for (int k = 0; k < 3; k++) tick();

    // Randomized traffic with occasional flush and asynchronous reset.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        drive(i, 1'($urandom_range(0, 1)), RW'($urandom), DW'($urandom));
      flush = ($urandom_range(0, 19) == 0);
      if (c % 97 == 50) async_reset_mid();
      else tick();
    end
    flush = 1'b0;
    clear_req();
    for (int c = 0; c < 10; c++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
